// File: rtl/patdet_pkg.sv
// Shared constants and prefix-match helpers for the serial pattern detector.
// Vectors are carried at PAT_W_MAX width; callers pass the live pattern length.
package patdet_pkg;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MAX = 32;
  localparam logic [PAT_W_MAX-1:0] DEFAULT_PAT = 16'b1001;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_STEP,
    ACT_MATCH_OVL,
    ACT_MATCH_RST
  } act_e;

  // seq[0] is the newest bit; the k newest bits are compared against the
  // first k pattern bits (pattern MSB at pw-1). Mask bits of 1 are don't-care.
  function automatic logic prefix_hit(input logic [PAT_W_MAX-1:0] seq, pat, msk,
                                      input int pw, input int k);
    logic [PAT_W_MAX-1:0] lo;
    lo = (PAT_W_MAX'(1) << k) - PAT_W_MAX'(1);
    return (((seq ^ (pat >> (pw - k))) & ~(msk >> (pw - k)) & lo) == '0);
  endfunction

  // Longest proper suffix of the pattern that is also its prefix.
  function automatic int overlap_len(input logic [PAT_W_MAX-1:0] pat, msk, input int pw);
    int r;
    r = 0;
    for (int k = 1; k < PAT_W_MAX; k++)
      if (k < pw && prefix_hit(pat, pat, msk, pw, k)) r = k;
    return r;
  endfunction
endpackage

// File: rtl/pattern_seq_detector_if.sv
// Control/data bundle of the serial pattern detector.
// Build option PATDET_MASK_EN adds the pat_mask_in signal.
interface pattern_seq_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic                     x, x_valid, pat_load, overlap_en, cnt_clr, z;
  logic [PAT_W-1:0]         pat_in;
  logic [CNT_W-1:0]         match_count;
  logic [$clog2(PAT_W)-1:0] state_o;
`ifdef PATDET_MASK_EN
  logic [PAT_W-1:0]         pat_mask_in;

  modport master (output x, x_valid, pat_load, pat_in, pat_mask_in, overlap_en, cnt_clr,
                  input z, match_count, state_o);
  modport slave  (input x, x_valid, pat_load, pat_in, pat_mask_in, overlap_en, cnt_clr,
                  output z, match_count, state_o);
`else
  modport master (output x, x_valid, pat_load, pat_in, overlap_en, cnt_clr,
                  input z, match_count, state_o);
  modport slave  (input x, x_valid, pat_load, pat_in, overlap_en, cnt_clr,
                  output z, match_count, state_o);
`endif
endinterface

// File: rtl/patdet_sat_counter.sv
// Saturating up-counter; clr wins over inc, never wraps past all-ones.
module patdet_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock or posedge reset)
    if (reset)                    count <= '0;
    else if (clr)                 count <= '0;
    else if (inc && count != '1)  count <= count + CNT_W'(1);
endmodule

// File: rtl/pattern_seq_detector.sv
// Mealy serial pattern detector: loadable pattern, overlap select, saturating match count.
// Build option PATDET_MASK_EN adds a per-position don't-care mask loaded with the pattern.
module pattern_seq_detector
  import patdet_pkg::*;
#(
  parameter int               PAT_W           = 4,
  parameter int               CNT_W           = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PATTERN = PAT_W'(DEFAULT_PAT)
) (
  input logic                   clock,
  input logic                   reset,
  pattern_seq_detector_if.slave bus
);
  localparam int SW = $clog2(PAT_W);
  localparam logic [SW-1:0] S_FULL = SW'(PAT_W - 1);

  logic [PAT_W-1:0] pattern, mask, window;
  logic [PAT_W-2:0] hist, hist_next;           // hist[0] = newest accepted bit
  logic [SW-1:0]    state, state_next, hist_len, hist_len_next;
  logic             accept, z_raw;
  act_e             act;
  int               scan, restart;

  always_ff @(posedge clock or posedge reset)
    if (reset)             pattern <= DEFAULT_PATTERN;
    else if (bus.pat_load) pattern <= bus.pat_in;

`ifdef PATDET_MASK_EN
  always_ff @(posedge clock or posedge reset)
    if (reset)             mask <= '0;
    else if (bus.pat_load) mask <= bus.pat_mask_in;
`else
  assign mask = '0;
`endif

  assign window = {hist, bus.x};
  assign accept = bus.x_valid & ~bus.pat_load;
  assign z_raw  = accept && (state == S_FULL) && (mask[0] || bus.x == pattern[0]);
  assign bus.z  = z_raw & ~reset;
  assign bus.state_o = state;

  // Longest pattern prefix ending on the incoming bit; hist_len keeps
  // cleared (non-accepted) history positions out of the comparison.
  always_comb begin
    scan = 0;
    for (int k = 1; k < PAT_W; k++)
      if (k <= int'(hist_len) + 1 &&
          prefix_hit(PAT_W_MAX'(window), PAT_W_MAX'(pattern), PAT_W_MAX'(mask), PAT_W, k))
        scan = k;
  end

  // With don't-cares the real bits decide the restart, so reuse the scan.
`ifdef PATDET_MASK_EN
  assign restart = scan;
`else
  assign restart = overlap_len(PAT_W_MAX'(pattern), '0, PAT_W);
`endif

  always_comb begin
    act = ACT_HOLD;
    if (bus.pat_load) act = ACT_LOAD;
    else if (z_raw)   act = bus.overlap_en ? ACT_MATCH_OVL : ACT_MATCH_RST;
    else if (accept)  act = ACT_STEP;

    state_next    = state;
    hist_next     = hist;
    hist_len_next = hist_len;
    case (act)
      ACT_HOLD: ;
      ACT_LOAD, ACT_MATCH_RST: begin
        state_next    = '0;
        hist_next     = '0;
        hist_len_next = '0;
      end
      ACT_STEP, ACT_MATCH_OVL: begin
        hist_next     = window[PAT_W-2:0];
        hist_len_next = (hist_len == S_FULL) ? S_FULL : hist_len + SW'(1);
        state_next    = (act == ACT_STEP) ? SW'(scan) : SW'(restart);
      end
      default: begin
        state_next    = '0;
        hist_next     = '0;
        hist_len_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= '0;
      hist     <= '0;
      hist_len <= '0;
    end else begin
      state    <= state_next;
      hist     <= hist_next;
      hist_len <= hist_len_next;
    end

  patdet_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (z_raw),
    .clr   (bus.cnt_clr),
    .count (bus.match_count)
  );
endmodule

// File: tb/tb_pattern_seq_detector.sv
// Bench for pattern_seq_detector: directed scenarios plus random stream vs a queue-based model.
module tb_pattern_seq_detector;
  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int SW      = $clog2(PAT_W);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pattern_seq_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus();
  pattern_seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: accepted bits since the last clear, newest at the back.
  logic [PAT_W-1:0] m_pat, m_msk;
  bit               m_q[$];
  int               m_cnt;
  logic             exp_z;
  int               exp_s, exp_cnt;

  function automatic bit m_tail_hit(input bit s[$], input int k);
    if (k > s.size()) return 1'b0;
    for (int j = 0; j < k; j++) begin
      int p;
      p = PAT_W - 1 - j;
      if (!m_msk[p] && s[s.size() - k + j] != m_pat[p]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int m_state();
    for (int k = PAT_W - 1; k >= 1; k--)
      if (m_tail_hit(m_q, k)) return k;
    return 0;
  endfunction

  task automatic m_reset();
    m_pat = PAT_W'(4'b1001);
    m_msk = '0;
    m_q.delete();
    m_cnt = 0;
  endtask

  // Drive one cycle, leave pre-edge expectations in exp_*, advance model past the edge.
  task automatic apply(input bit xi, input bit xv, input bit ld, input logic [PAT_W-1:0] pin,
                       input logic [PAT_W-1:0] pmsk, input bit ovl, input bit clr);
    bit nq[$];
    @(negedge clock);
    bus.x = xi; bus.x_valid = xv; bus.pat_load = ld; bus.pat_in = pin;
    bus.overlap_en = ovl; bus.cnt_clr = clr;
`ifdef PATDET_MASK_EN
    bus.pat_mask_in = pmsk;
`endif
    #1;
    exp_s   = m_state();
    exp_cnt = m_cnt;
    nq = m_q;
    nq.push_back(xi);
    exp_z = xv && !ld && m_tail_hit(nq, PAT_W);
    if (ld) begin
      m_pat = pin;
      m_msk = pmsk;
      m_q.delete();
    end else if (xv) begin
      m_q = nq;
      if (exp_z && !ovl) m_q.delete();
      while (m_q.size() > PAT_W) void'(m_q.pop_front());
    end
    if (clr) m_cnt = 0;
    else if (exp_z && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic hw_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.x_valid = 1'b0; bus.pat_load = 1'b0; bus.cnt_clr = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.x = 1'b1; bus.x_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    tests++;
    if (bus.z !== 1'b0 || bus.state_o !== '0 || bus.match_count !== '0) begin
      fails++;
      $display("FAIL reset: z=%b s=%0d cnt=%0d, want 0/0/0", bus.z, bus.state_o, bus.match_count);
    end
    bus.x_valid = 1'b0;
    reset = 1'b0;
    m_reset();
  endtask

  task automatic test_overlap();
    bit bits[7] = '{1, 0, 0, 1, 0, 0, 1};
    bit zs[7]   = '{0, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      apply(bits[i], 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
      tests++;
      if (bus.z !== zs[i] || bus.state_o !== SW'(exp_s) || bus.match_count !== CNT_W'(exp_cnt)) begin
        fails++;
        $display("FAIL overlap[%0d]: z=%b s=%0d cnt=%0d, want z=%b s=%0d cnt=%0d",
                 i, bus.z, bus.state_o, bus.match_count, zs[i], exp_s, exp_cnt);
      end
      if (i == 4) begin
        tests++;
        if (bus.state_o !== SW'(1)) begin
          fails++;
          $display("FAIL overlap restart: s=%0d, want 1", bus.state_o);
        end
      end
    end
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    tests++;
    if (bus.match_count !== CNT_W'(2)) begin
      fails++;
      $display("FAIL overlap count: got %0d want 2", bus.match_count);
    end
  endtask

  task automatic test_nonoverlap();
    bit bits[7] = '{1, 0, 0, 1, 0, 0, 1};
    bit zs[7]   = '{0, 0, 0, 1, 0, 0, 0};
    hw_reset();
    for (int i = 0; i < 7; i++) begin
      apply(bits[i], 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      tests++;
      if (bus.z !== zs[i] || bus.state_o !== SW'(exp_s) || bus.match_count !== CNT_W'(exp_cnt)) begin
        fails++;
        $display("FAIL nonoverlap[%0d]: z=%b s=%0d cnt=%0d, want z=%b s=%0d cnt=%0d",
                 i, bus.z, bus.state_o, bus.match_count, zs[i], exp_s, exp_cnt);
      end
      if (i == 4) begin
        tests++;
        if (bus.state_o !== SW'(0)) begin
          fails++;
          $display("FAIL nonoverlap restart: s=%0d, want 0", bus.state_o);
        end
      end
    end
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    tests++;
    if (bus.match_count !== CNT_W'(1)) begin
      fails++;
      $display("FAIL nonoverlap count: got %0d want 1", bus.match_count);
    end
  endtask

  task automatic test_gaps();
    bit xs[7] = '{1, 1, 0, 0, 1, 0, 1};
    bit vs[7] = '{1, 0, 1, 0, 0, 1, 1};
    bit zs[7] = '{0, 0, 0, 0, 0, 0, 1};
    hw_reset();
    for (int i = 0; i < 7; i++) begin
      apply(vs[i] ? xs[i] : ($urandom_range(1) == 1), vs[i], 1'b0, '0, '0, 1'b1, 1'b0);
      tests++;
      if (bus.z !== zs[i] || bus.state_o !== SW'(exp_s) || bus.match_count !== CNT_W'(exp_cnt)) begin
        fails++;
        $display("FAIL gaps[%0d]: z=%b s=%0d cnt=%0d, want z=%b s=%0d cnt=%0d",
                 i, bus.z, bus.state_o, bus.match_count, zs[i], exp_s, exp_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    hw_reset();
    apply(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      apply(i % 3 == 2, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
      tests++;
      if (bus.z !== (i % 3 == 2) || bus.match_count !== CNT_W'(exp_cnt)) begin
        fails++;
        $display("FAIL saturation[%0d]: z=%b cnt=%0d, want z=%b cnt=%0d",
                 i, bus.z, bus.match_count, (i % 3 == 2), exp_cnt);
      end
    end
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    tests++;
    if (bus.match_count !== CNT_W'(3)) begin
      fails++;
      $display("FAIL saturation count: got %0d want 3", bus.match_count);
    end
    apply(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
    tests++;
    if (bus.z !== 1'b1) begin
      fails++;
      $display("FAIL clr_vs_z pulse: z=%b want 1", bus.z);
    end
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    tests++;
    if (bus.match_count !== '0) begin
      fails++;
      $display("FAIL clr_vs_z count: got %0d want 0", bus.match_count);
    end
  endtask

  task automatic test_load();
    bit bits[7] = '{0, 1, 1, 0, 1, 1, 0};
    bit zs[7]   = '{0, 0, 0, 1, 0, 0, 1};
    apply(1'b1, 1'b1, 1'b1, PAT_W'(4'b0110), '0, 1'b1, 1'b0);
    tests++;
    if (bus.z !== 1'b0) begin
      fails++;
      $display("FAIL load z: got %b want 0", bus.z);
    end
    for (int i = 0; i < 7; i++) begin
      apply(bits[i], 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
      tests++;
      if (bus.z !== zs[i] || bus.state_o !== SW'(exp_s) || bus.match_count !== CNT_W'(exp_cnt)) begin
        fails++;
        $display("FAIL load[%0d]: z=%b s=%0d cnt=%0d, want z=%b s=%0d cnt=%0d",
                 i, bus.z, bus.state_o, bus.match_count, zs[i], exp_s, exp_cnt);
      end
      if (i == 0) begin
        tests++;
        if (bus.state_o !== SW'(0)) begin
          fails++;
          $display("FAIL load state: s=%0d want 0", bus.state_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit bits[3] = '{1, 0, 0};
    apply(1'b0, 1'b0, 1'b1, PAT_W'(4'b0110), '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply(bits[i], 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clock);
    bus.x = 1'b1; bus.x_valid = 1'b1; bus.pat_load = 1'b0; bus.cnt_clr = 1'b0;
    #1;
    tests++;
    if (bus.state_o !== SW'(m_state()) || bus.match_count !== CNT_W'(m_cnt)) begin
      fails++;
      $display("FAIL pre_reset: s=%0d cnt=%0d, want s=%0d cnt=%0d",
               bus.state_o, bus.match_count, m_state(), m_cnt);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (bus.z !== 1'b0 || bus.state_o !== '0 || bus.match_count !== '0) begin
      fails++;
      $display("FAIL async_reset: z=%b s=%0d cnt=%0d, want 0/0/0", bus.z, bus.state_o, bus.match_count);
    end
    #1;
    reset = 1'b0;
    bus.x_valid = 1'b0;
    m_reset();
    apply(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    tests++;
    if (bus.z !== 1'b0) begin
      fails++;
      $display("FAIL post_reset z: got %b want 0", bus.z);
    end
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    tests++;
    if (bus.state_o !== SW'(1) || bus.match_count !== '0) begin
      fails++;
      $display("FAIL post_reset: s=%0d cnt=%0d, want s=1 cnt=0", bus.state_o, bus.match_count);
    end
  endtask

  task automatic test_random();
    bit ovl = 1'b1;
    hw_reset();
    for (int i = 0; i < 3000; i++) begin
      bit               ld;
      logic [PAT_W-1:0] pin, pm;
      ld  = ($urandom_range(39) == 0);
      pin = PAT_W'($urandom);
      pm  = '0;
`ifdef PATDET_MASK_EN
      if ($urandom_range(3) == 0) pm = PAT_W'($urandom);
`endif
      if ($urandom_range(15) == 0) ovl = ~ovl;
      apply($urandom_range(1) == 1, $urandom_range(3) != 0, ld, pin, pm, ovl,
            $urandom_range(31) == 0);
      tests++;
      if (bus.z !== exp_z || bus.state_o !== SW'(exp_s) || bus.match_count !== CNT_W'(exp_cnt)) begin
        fails++;
        $display("FAIL random[%0d]: z=%b s=%0d cnt=%0d, want z=%b s=%0d cnt=%0d",
                 i, bus.z, bus.state_o, bus.match_count, exp_z, exp_s, exp_cnt);
      end
    end
  endtask

`ifdef PATDET_MASK_EN
  task automatic test_mask();
    bit bits[4] = '{1, 1, 0, 1};
    bit zs[4]   = '{0, 0, 0, 1};
    hw_reset();
    apply(1'b0, 1'b0, 1'b1, PAT_W'(4'b1001), PAT_W'(4'b0110), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(bits[i], 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
      tests++;
      if (bus.z !== zs[i] || bus.state_o !== SW'(exp_s)) begin
        fails++;
        $display("FAIL mask[%0d]: z=%b s=%0d, want z=%b s=%0d", i, bus.z, bus.state_o, zs[i], exp_s);
      end
    end
  endtask
`endif

  initial begin
    bus.x = 1'b0; bus.x_valid = 1'b0; bus.pat_load = 1'b0; bus.pat_in = '0;
    bus.overlap_en = 1'b1; bus.cnt_clr = 1'b0;
`ifdef PATDET_MASK_EN
    bus.pat_mask_in = '0;
`endif
    m_reset();
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_saturation();
    test_load();
    test_reset_mid();
    test_random();
`ifdef PATDET_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
